// File: rtl/pnm_act_pkg.sv
// Shared definitions for the activation stream controller: mode encodings,
// controller state encoding and the page-index width helper.
package pnm_act_pkg;

    localparam logic [1:0] MODE_RELU  = 2'b00;
    localparam logic [1:0] MODE_LEAKY = 2'b01;
    localparam logic [1:0] MODE_CLAMP = 2'b10;
    localparam logic [1:0] MODE_PASS  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    function automatic int page_bits(input int num_pages);
        return $clog2(num_pages);
    endfunction

endpackage

// File: rtl/act_unit.sv
// Combinational activation function: ReLU, leaky ReLU, ReLU-N clamp or
// passthrough on one signed element.
module act_unit
    import pnm_act_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [DATA_WIDTH-1:0] act_in,
    input  logic        [1:0]            mode,
    input  logic signed [DATA_WIDTH-1:0] clamp_max,
    output logic signed [DATA_WIDTH-1:0] act_out
);

    // Select the activation result; non-negative inputs pass unchanged
    // except where the clamp bound applies.
    always_comb begin
        act_out = act_in;
        case (mode)
            MODE_RELU: begin
                if (act_in < 0) act_out = '0;
            end
            MODE_LEAKY: begin
                if (act_in < 0) act_out = act_in >>> LEAK_SHIFT;
            end
            MODE_CLAMP: begin
                if (act_in < 0)              act_out = '0;
                else if (act_in > clamp_max) act_out = clamp_max;
            end
            MODE_PASS: act_out = act_in;
            default:   act_out = act_in;
        endcase
    end

endmodule

// File: rtl/activation_stream_ctrl.sv
// Streams a source address range through the activation unit and writes the
// results to a destination range using a valid/ready write handshake.
// Optional feature macro: ACT_STATS_EN adds neg_count (negative inputs seen).
//
// state    | meaning
// ST_IDLE  | waiting for start; range check, error pulse on inverted range
// ST_RUN   | issuing one read per non-stalled cycle
// ST_DRAIN | all reads issued, waiting for the last write to be accepted
// ST_DONE  | one-cycle done pulse, then back to idle
module activation_stream_ctrl
    import pnm_act_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int Address_Size = 16,
    parameter int NUM_PAGES    = 64,
    parameter int LEAK_SHIFT   = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [1:0]                       mode,
    input  logic [DATA_WIDTH-1:0]            clamp_max,
    input  logic [Address_Size-1:0]          start_addr,
    input  logic [Address_Size-1:0]          end_addr,
    input  logic [Address_Size-1:0]          result_addr,
    input  logic [DATA_WIDTH*NUM_PAGES-1:0]  din_all,
    output logic [Address_Size-1:0]          rd_addr,
    output logic                             rd_en,
    output logic [Address_Size-1:0]          wr_addr,
    output logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             wr_valid,
    input  logic                             wr_ready,
    output logic                             busy,
    output logic                             done,
`ifdef ACT_STATS_EN
    output logic [Address_Size:0]            neg_count,
`endif
    output logic                             err
);

    localparam int PAGE_BITS = page_bits(NUM_PAGES);
    localparam int CW        = Address_Size + 1;
    localparam logic [Address_Size-1:0] ADDR_ONE = Address_Size'(1);
    localparam logic [CW-1:0]           CNT_ONE  = CW'(1);

    state_t                         state_q, state_d;
    logic [1:0]                     mode_q, mode_d;
    logic signed [DATA_WIDTH-1:0]   clamp_q, clamp_d;
    logic [Address_Size-1:0]        rd_addr_q, rd_addr_d;
    logic [Address_Size-1:0]        wr_addr_q, wr_addr_d;
    logic [CW-1:0]                  iss_rem_q, iss_rem_d;
    logic [CW-1:0]                  acc_rem_q, acc_rem_d;
    logic                           err_q, err_d;
    logic                           cap_vld_q, cap_vld_d;
    logic signed [DATA_WIDTH-1:0]   cap_q, cap_d;
    logic                           wr_valid_q, wr_valid_d;
    logic signed [DATA_WIDTH-1:0]   out_q, out_d;

    logic                           stall;
    logic                           rd_fire;
    logic                           wr_fire;
    logic [PAGE_BITS-1:0]           page_idx;
    logic [DATA_WIDTH-1:0]          pages [NUM_PAGES];
    logic signed [DATA_WIDTH-1:0]   rd_data;
    logic signed [DATA_WIDTH-1:0]   act_res;

    for (genvar g = 0; g < NUM_PAGES; g++) begin : g_page
        assign pages[g] = din_all[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign page_idx = rd_addr_q[Address_Size-1 -: PAGE_BITS];
    assign rd_data  = pages[page_idx];

    // A pending write that is not taken freezes the entire pipeline.
    assign stall   = wr_valid_q && !wr_ready;
    assign wr_fire = wr_valid_q && wr_ready;
    assign rd_fire = (state_q == ST_RUN) && !stall;

    act_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_act (
        .act_in    (cap_q),
        .mode      (mode_q),
        .clamp_max (clamp_q),
        .act_out   (act_res)
    );

    // Next-state, address and element-count control.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        clamp_d   = clamp_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        iss_rem_d = iss_rem_q;
        acc_rem_d = acc_rem_q;
        err_d     = 1'b0;

        if (wr_fire) begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
            acc_rem_d = acc_rem_q - CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (end_addr >= start_addr) begin
                        mode_d    = mode;
                        clamp_d   = clamp_max;
                        rd_addr_d = start_addr;
                        wr_addr_d = result_addr;
                        iss_rem_d = CW'(end_addr) - CW'(start_addr) + CNT_ONE;
                        acc_rem_d = CW'(end_addr) - CW'(start_addr) + CNT_ONE;
                        state_d   = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (rd_fire) begin
                    rd_addr_d = rd_addr_q + ADDR_ONE;
                    iss_rem_d = iss_rem_q - CNT_ONE;
                    if (iss_rem_q == CNT_ONE) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_fire && (acc_rem_q == CNT_ONE)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture then output stage; both advance together unless stalled.
    always_comb begin
        cap_vld_d  = cap_vld_q;
        cap_d      = cap_q;
        wr_valid_d = wr_valid_q;
        out_d      = out_q;
        if (!stall) begin
            cap_vld_d  = rd_fire;
            if (rd_fire) cap_d = rd_data;
            wr_valid_d = cap_vld_q;
            if (cap_vld_q) out_d = act_res;
        end
    end

    // Control and pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            clamp_q    <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            iss_rem_q  <= '0;
            acc_rem_q  <= '0;
            err_q      <= 1'b0;
            cap_vld_q  <= 1'b0;
            cap_q      <= '0;
            wr_valid_q <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            clamp_q    <= clamp_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            iss_rem_q  <= iss_rem_d;
            acc_rem_q  <= acc_rem_d;
            err_q      <= err_d;
            cap_vld_q  <= cap_vld_d;
            cap_q      <= cap_d;
            wr_valid_q <= wr_valid_d;
            out_q      <= out_d;
        end
    end

`ifdef ACT_STATS_EN
    logic                 out_neg_q, out_neg_d;
    logic [CW-1:0]        neg_q, neg_d;

    // Track the sign of the element held in the output stage and count
    // negatives as their writes are accepted.
    always_comb begin
        out_neg_d = out_neg_q;
        neg_d     = neg_q;
        if (!stall && cap_vld_q) out_neg_d = cap_q[DATA_WIDTH-1];
        if ((state_q == ST_IDLE) && start && (end_addr >= start_addr)) begin
            neg_d = '0;
        end else if (wr_fire && out_neg_q) begin
            neg_d = neg_q + CNT_ONE;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_neg_q <= 1'b0;
            neg_q     <= '0;
        end else begin
            out_neg_q <= out_neg_d;
            neg_q     <= neg_d;
        end
    end

    assign neg_count = neg_q;
`endif

    assign rd_addr  = rd_addr_q;
    assign rd_en    = rd_fire;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = out_q;
    assign wr_valid = wr_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE) || err_q;
    assign err      = err_q;

endmodule

// File: tb/tb_activation_stream_ctrl.sv
// Directed testbench for activation_stream_ctrl. The bench acts as the
// paged source memory and the write sink.
module tb_activation_stream_ctrl;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NP = 64;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [1:0]        mode;
    logic [DW-1:0]     clamp_max;
    logic [AW-1:0]     start_addr, end_addr, result_addr;
    logic [DW*NP-1:0]  din_all;
    logic [AW-1:0]     rd_addr;
    logic              rd_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              busy, done, err;
`ifdef ACT_STATS_EN
    logic [AW:0]       neg_count;
`endif

    logic [DW-1:0]     mem [256];

    int tests_run    = 0;
    int tests_failed = 0;

    // results collected by run_op
    logic [AW-1:0] wa [16];
    logic [DW-1:0] wd [16];
    int nw, first_rd, first_wv, done_cyc, last_w_cyc, err_cyc;
    int rd_count, done_count, hold_bad, rd_in_stall;
    bit busy_seen, timed_out;

    activation_stream_ctrl #(
        .DATA_WIDTH   (DW),
        .Address_Size (AW),
        .NUM_PAGES    (NP),
        .LEAK_SHIFT   (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .clamp_max   (clamp_max),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .result_addr (result_addr),
        .din_all     (din_all),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .busy        (busy),
        .done        (done),
`ifdef ACT_STATS_EN
        .neg_count   (neg_count),
`endif
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only the page selected by the top address bits carries real data.
    always_comb begin
        for (int p = 0; p < NP; p++) din_all[p*DW +: DW] = 32'hBAD0_0000 | 32'(p);
        din_all[int'(rd_addr[AW-1 -: 6])*DW +: DW] = mem[rd_addr[7:0]];
    end

    // Issue one start from the current cycle and observe until done.
    task automatic run_op(input logic [1:0] m, input logic [DW-1:0] cmax,
                          input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                          input logic [AW-1:0] ra, input int stall_idx, input int stall_len);
        int stall_left;
        bit holding;
        logic [AW-1:0] h_wa, h_ra;
        logic [DW-1:0] h_wd;
        nw = 0; first_rd = -1; first_wv = -1; done_cyc = -1; last_w_cyc = -1; err_cyc = -1;
        rd_count = 0; done_count = 0; hold_bad = 0; rd_in_stall = 0;
        busy_seen = 0; timed_out = 0;
        stall_left = stall_len; holding = 0;
        mode = m; clamp_max = cmax; start_addr = sa; end_addr = ea; result_addr = ra;
        wr_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            wr_ready = 1'b1;
            if (wr_valid && nw == stall_idx && stall_left > 0) begin
                wr_ready = 1'b0;
                stall_left--;
            end
            #1;
            if (!wr_ready) begin
                if (rd_en) rd_in_stall++;
                if (!holding) begin
                    holding = 1; h_wa = wr_addr; h_wd = wr_data; h_ra = rd_addr;
                end else if (wr_addr !== h_wa || wr_data !== h_wd || rd_addr !== h_ra) begin
                    hold_bad++;
                end
            end
            if (rd_en) begin
                rd_count++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (busy) busy_seen = 1;
            if (err && err_cyc < 0) err_cyc = cyc;
            if (wr_valid && first_wv < 0) first_wv = cyc;
            if (wr_valid && wr_ready) begin
                if (nw < 16) begin
                    wa[nw] = wr_addr; wd[nw] = wr_data;
                end
                nw++;
                last_w_cyc = cyc;
            end
            if (done) begin
                done_count++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(posedge clk); #1;
        end
        if (done_cyc < 0) timed_out = 1;
        wr_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1; mode = 2'b00;
        clamp_max = '0; start_addr = '0; end_addr = '0; result_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({rd_en, wr_valid, busy, done, err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000", {rd_en, wr_valid, busy, done, err});
        end
        tests_run++;
        if (rd_addr !== 16'h0 || wr_addr !== 16'h0 || wr_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got rd=%h wr=%h d=%h expected zeros", rd_addr, wr_addr, wr_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_relu();
        int exp_d [4] = '{5, 0, 0, 0};
        mem[8'h10] = 5; mem[8'h11] = -3; mem[8'h12] = 0; mem[8'h13] = -1;
        run_op(2'b00, 32'd0, 16'h0010, 16'h0013, 16'h0100, -1, 0);
        tests_run++;
        if (timed_out || nw != 4) begin
            tests_failed++;
            $display("FAIL relu_count: got %0d writes (timeout=%0d) expected 4", nw, timed_out);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (wa[k] !== 16'h0100 + 16'(k) || wd[k] !== 32'(exp_d[k])) begin
                tests_failed++;
                $display("FAIL relu_write[%0d]: got %h=%h expected %h=%h", k, wa[k], wd[k],
                         16'h0100 + 16'(k), 32'(exp_d[k]));
            end
        end
        tests_run++;
        if (first_rd != 1 || first_wv - first_rd != 2) begin
            tests_failed++;
            $display("FAIL relu_latency: got rd@%0d wv@%0d expected rd@1 wv@3", first_rd, first_wv);
        end
        tests_run++;
        if (done_cyc != last_w_cyc + 1 || done_count != 1 || err_cyc != -1 || rd_count != 4) begin
            tests_failed++;
            $display("FAIL relu_done: got done@%0d last_w@%0d pulses=%0d err@%0d rds=%0d expected done=last_w+1,1,-1,4",
                     done_cyc, last_w_cyc, done_count, err_cyc, rd_count);
        end
    endtask

    task automatic test_leaky();
        int exp_d [3] = '{-2, -1, 8};
        mem[8'h00] = -16; mem[8'h01] = -1; mem[8'h02] = 8;
        run_op(2'b01, 32'd0, 16'h0C00, 16'h0C02, 16'h0200, -1, 0);
        tests_run++;
        if (timed_out || nw != 3) begin
            tests_failed++;
            $display("FAIL leaky_count: got %0d writes expected 3", nw);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (wa[k] !== 16'h0200 + 16'(k) || wd[k] !== 32'(exp_d[k])) begin
                tests_failed++;
                $display("FAIL leaky_write[%0d]: got %h=%h expected %h=%h", k, wa[k], wd[k],
                         16'h0200 + 16'(k), 32'(exp_d[k]));
            end
        end
    endtask

    task automatic test_clamp_stall();
        int exp_d [3] = '{0, 3, 6};
        mem[8'h20] = -4; mem[8'h21] = 3; mem[8'h22] = 9;
        run_op(2'b10, 32'd6, 16'h0020, 16'h0022, 16'h0300, 1, 3);
        tests_run++;
        if (timed_out || nw != 3 || done_count != 1) begin
            tests_failed++;
            $display("FAIL clamp_count: got %0d writes %0d done expected 3 and 1", nw, done_count);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (wa[k] !== 16'h0300 + 16'(k) || wd[k] !== 32'(exp_d[k])) begin
                tests_failed++;
                $display("FAIL clamp_write[%0d]: got %h=%h expected %h=%h", k, wa[k], wd[k],
                         16'h0300 + 16'(k), 32'(exp_d[k]));
            end
        end
        tests_run++;
        if (hold_bad != 0) begin
            tests_failed++;
            $display("FAIL clamp_hold: got %0d changes during stall expected 0", hold_bad);
        end
    endtask

    task automatic test_stall_run();
        int vals [6] = '{1, -2, 3, -4, 5, 6};
        for (int k = 0; k < 6; k++) mem[8'h50 + 8'(k)] = 32'(vals[k]);
        run_op(2'b11, 32'd0, 16'h0050, 16'h0055, 16'h0400, 0, 2);
        tests_run++;
        if (timed_out || nw != 6 || rd_count != 6) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d writes %0d reads expected 6 and 6", nw, rd_count);
        end
        tests_run++;
        if (rd_in_stall != 0 || hold_bad != 0) begin
            tests_failed++;
            $display("FAIL stall_hold: got rd_en=%0d changes=%0d during stall expected 0 0", rd_in_stall, hold_bad);
        end
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (wa[k] !== 16'h0400 + 16'(k) || wd[k] !== 32'(vals[k])) begin
                tests_failed++;
                $display("FAIL stall_write[%0d]: got %h=%h expected %h=%h", k, wa[k], wd[k],
                         16'h0400 + 16'(k), 32'(vals[k]));
            end
        end
    endtask

    task automatic test_single();
        mem[8'h40] = 32'h7FFF_FFFF;
        run_op(2'b10, 32'd100, 16'h0040, 16'h0040, 16'h0500, -1, 0);
        tests_run++;
        if (timed_out || nw != 1 || wa[0] !== 16'h0500 || wd[0] !== 32'd100) begin
            tests_failed++;
            $display("FAIL single: got n=%0d %h=%h expected n=1 0500=00000064", nw, wa[0], wd[0]);
        end
    endtask

    task automatic test_error();
        run_op(2'b00, 32'd0, 16'h0008, 16'h0005, 16'h0600, -1, 0);
        tests_run++;
        if (err_cyc != 1 || done_cyc != 1 || done_count != 1) begin
            tests_failed++;
            $display("FAIL error_pulse: got err@%0d done@%0d pulses=%0d expected 1 1 1", err_cyc, done_cyc, done_count);
        end
        tests_run++;
        if (rd_count != 0 || busy_seen || nw != 0) begin
            tests_failed++;
            $display("FAIL error_quiet: got rds=%0d busy=%0d writes=%0d expected 0 0 0", rd_count, busy_seen, nw);
        end
    endtask

    task automatic test_reset_midrun();
        for (int k = 0; k < 8; k++) mem[8'h60 + 8'(k)] = 32'(k + 1);
        mode = 2'b11; clamp_max = '0; start_addr = 16'h0060; end_addr = 16'h0067;
        result_addr = 16'h0700; wr_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({rd_en, wr_valid, busy, done, err} !== 5'b0 || rd_addr !== 16'h0 ||
            wr_addr !== 16'h0 || wr_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrun_reset: got ctrl=%b rd=%h wr=%h d=%h expected all zero",
                     {rd_en, wr_valid, busy, done, err}, rd_addr, wr_addr, wr_data);
        end
        rst_n = 1'b1;
        run_op(2'b00, 32'd0, 16'h0010, 16'h0013, 16'h0100, -1, 0);
        tests_run++;
        if (timed_out || nw != 4 || done_count != 1 || wa[3] !== 16'h0103 || wd[0] !== 32'd5 || wd[1] !== 32'd0) begin
            tests_failed++;
            $display("FAIL midrun_restart: got n=%0d done=%0d a3=%h d0=%h d1=%h expected 4 1 0103 5 0",
                     nw, done_count, wa[3], wd[0], wd[1]);
        end
    endtask

    task automatic test_wrap_stats();
        int vals [4] = '{-1, 2, -3, -4};
        logic [AW-1:0] exp_a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        for (int k = 0; k < 4; k++) mem[8'h30 + 8'(k)] = 32'(vals[k]);
        run_op(2'b11, 32'd0, 16'h0030, 16'h0033, 16'hFFFE, -1, 0);
        tests_run++;
        if (timed_out || nw != 4) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d writes expected 4", nw);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (wa[k] !== exp_a[k] || wd[k] !== 32'(vals[k])) begin
                tests_failed++;
                $display("FAIL wrap_write[%0d]: got %h=%h expected %h=%h", k, wa[k], wd[k], exp_a[k], 32'(vals[k]));
            end
        end
`ifdef ACT_STATS_EN
        tests_run++;
        if (neg_count !== 17'd3) begin
            tests_failed++;
            $display("FAIL neg_count: got %0d expected 3", neg_count);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (neg_count !== 17'd3) begin
            tests_failed++;
            $display("FAIL neg_count_stable: got %0d expected 3", neg_count);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_relu();
        test_leaky();
        test_clamp_stall();
        test_stall_run();
        test_single();
        test_error();
        test_reset_midrun();
        test_wrap_stats();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
